// File: rtl/mc6845_char_serializer.sv
// ============================================================================
// Module   : mc6845_char_serializer
// Purpose  : Fetches character code and font row for each MC6845 character,
//            then shifts the row out one dot per clock with syncs/DE aligned.
//            Optional cursor blink: define CURSOR_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc6845_char_serializer #(
    parameter int CHAR_WIDTH   = 8,
    parameter int MA_W         = 14,
    parameter int BLINK_FIELDS = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CHAR_EN,
    input  logic [MA_W-1:0] MA,
    input  logic [4:0]      RA,
    input  logic            DE,
    input  logic            CURSOR,
    input  logic            HSYNC_IN,
    input  logic            VSYNC_IN,
    output logic [MA_W-1:0] VRAM_ADDR,
    output logic            VRAM_RD,
    input  logic [7:0]      VRAM_DATA,
    output logic [11:0]     FONT_ADDR,
    output logic            FONT_RD,
    input  logic [7:0]      FONT_DATA,
    output logic            PIXEL,
    output logic            PIX_DE,
    output logic            HSYNC_OUT,
    output logic            VSYNC_OUT,
    output logic            LATE
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_VRAM_REQ  = 3'd1;
    localparam logic [2:0] c_FONT_REQ  = 3'd2;
    localparam logic [2:0] c_FONT_WAIT = 3'd3;
    localparam logic [2:0] c_READY     = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [4:0] r_ra_l;
    logic       r_de_l;
    logic       r_cursor_l;
    logic       r_hsync_l;
    logic       r_vsync_l;
    logic [7:0] r_pend;
    logic [7:0] r_shift;
    logic       w_load_ok;
    logic       w_late;
    logic       w_font_req;
    logic       w_row_take;
    logic       w_blink_phase;
    logic       w_cursor_on;
    logic [7:0] w_row;
    logic       w_unused_cfg;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state: a character strobe always restarts the fetch.
    // FONT_WAIT spans two edges; FONT_RD high marks the first of them.
    always_comb begin
        w_state_nxt = r_state;
        if (CHAR_EN) begin
            w_state_nxt = c_VRAM_REQ;
        end else begin
            case (r_state)
                c_VRAM_REQ:  w_state_nxt = c_FONT_REQ;
                c_FONT_REQ:  w_state_nxt = c_FONT_WAIT;
                c_FONT_WAIT: w_state_nxt = FONT_RD ? c_FONT_WAIT : c_READY;
                default:     w_state_nxt = r_state;
            endcase
        end
    end

    // Output decode
    always_comb begin
        w_load_ok  = CHAR_EN && (r_state == c_READY);
        w_late     = CHAR_EN && (r_state != c_READY) && (r_state != c_IDLE);
        w_font_req = !CHAR_EN && (r_state == c_FONT_REQ);
        w_row_take = !CHAR_EN && (r_state == c_FONT_WAIT) && !FONT_RD;
    end

`ifdef CURSOR_BLINK_EN
    localparam int c_BLINK_W = (BLINK_FIELDS > 1) ? $clog2(BLINK_FIELDS) : 1;

    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blink_phase;

    // VSYNC rising edge is judged against the previous character's latch
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (CHAR_EN && VSYNC_IN && !r_vsync_l) begin
            if (r_blink_cnt == c_BLINK_W'(BLINK_FIELDS - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_blink_phase = r_blink_phase;
    assign w_unused_cfg  = (CHAR_WIDTH > 0);
`else
    assign w_blink_phase = 1'b1;
    assign w_unused_cfg  = (CHAR_WIDTH > 0) && (BLINK_FIELDS > 0);
`endif

    assign w_cursor_on = r_cursor_l & r_de_l & w_blink_phase;
    assign w_row       = (r_ra_l[4] ? 8'h00 : FONT_DATA) ^ {8{w_cursor_on}};

    // Fetch path
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ra_l     <= '0;
            r_de_l     <= 1'b0;
            r_cursor_l <= 1'b0;
            r_hsync_l  <= 1'b0;
            r_vsync_l  <= 1'b0;
            VRAM_ADDR  <= '0;
            VRAM_RD    <= 1'b0;
            FONT_ADDR  <= '0;
            FONT_RD    <= 1'b0;
            r_pend     <= '0;
        end else begin
            VRAM_RD <= CHAR_EN;
            FONT_RD <= w_font_req;
            if (CHAR_EN) begin
                r_ra_l     <= RA;
                r_de_l     <= DE;
                r_cursor_l <= CURSOR;
                r_hsync_l  <= HSYNC_IN;
                r_vsync_l  <= VSYNC_IN;
                VRAM_ADDR  <= MA;
            end
            if (w_font_req) FONT_ADDR <= {VRAM_DATA, r_ra_l[3:0]};
            if (w_row_take) r_pend    <= w_row;
        end
    end

    // Pixel path: loads use the previous character's latches, read before
    // the fetch path overwrites them on this same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_shift   <= '0;
            PIX_DE    <= 1'b0;
            HSYNC_OUT <= 1'b0;
            VSYNC_OUT <= 1'b0;
            LATE      <= 1'b0;
        end else begin
            if (CHAR_EN) begin
                r_shift   <= (w_load_ok && r_de_l) ? r_pend : 8'h00;
                PIX_DE    <= w_load_ok && r_de_l;
                HSYNC_OUT <= r_hsync_l;
                VSYNC_OUT <= r_vsync_l;
            end else begin
                r_shift <= {r_shift[6:0], 1'b0};
            end
            if (w_late) LATE <= 1'b1;
        end
    end

    assign PIXEL = r_shift[7];

endmodule

`default_nettype wire

// File: tb/tb_mc6845_char_serializer.sv
// ============================================================================
// Module   : tb_mc6845_char_serializer
// Purpose  : Scoreboard bench; memory models, character-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc6845_char_serializer;

    localparam int MA_W = 14;
    localparam int BF   = 2;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            CHAR_EN = 1'b0;
    logic [MA_W-1:0] MA = '0;
    logic [4:0]      RA = '0;
    logic            DE = 1'b0, CURSOR = 1'b0, HSYNC_IN = 1'b0, VSYNC_IN = 1'b0;
    logic [MA_W-1:0] VRAM_ADDR;
    logic            VRAM_RD, FONT_RD;
    logic [7:0]      VRAM_DATA = '0, FONT_DATA = '0;
    logic [11:0]     FONT_ADDR;
    logic            PIXEL, PIX_DE, HSYNC_OUT, VSYNC_OUT, LATE;

    mc6845_char_serializer #(.CHAR_WIDTH(8), .MA_W(MA_W), .BLINK_FIELDS(BF)) dut (
        .CLK(CLK), .RST(RST), .CHAR_EN(CHAR_EN), .MA(MA), .RA(RA), .DE(DE),
        .CURSOR(CURSOR), .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN),
        .VRAM_ADDR(VRAM_ADDR), .VRAM_RD(VRAM_RD), .VRAM_DATA(VRAM_DATA),
        .FONT_ADDR(FONT_ADDR), .FONT_RD(FONT_RD), .FONT_DATA(FONT_DATA),
        .PIXEL(PIXEL), .PIX_DE(PIX_DE), .HSYNC_OUT(HSYNC_OUT),
        .VSYNC_OUT(VSYNC_OUT), .LATE(LATE)
    );

    always #5 CLK = ~CLK;

    logic [7:0] vram [0:(1<<MA_W)-1];
    logic [7:0] font [0:4095];

    // Synchronous memories: data valid the cycle after the sampled read strobe
    always @(posedge CLK) begin
        if (VRAM_RD) VRAM_DATA <= vram[VRAM_ADDR];
        if (FONT_RD) FONT_DATA <= font[FONT_ADDR];
    end

    typedef struct {
        logic [7:0] row;
        logic       de, hs, vs, late;
        int         n;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   font_pulses = 0;

    // Reference model: one record per character, no cycle detail
    bit         m_valid;
    logic [7:0] m_row;
    logic       m_de, m_hs, m_vs, m_late;
    int         m_gap;
    int         m_bcnt;
    bit         m_phase;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_row = 0; m_de = 0; m_hs = 0; m_vs = 0; m_late = 0;
        m_gap = 0; m_bcnt = 0; m_phase = 0;
    endtask

    // Called at a negedge; issues one character and holds for gap clocks
    task automatic drive_char(input logic [MA_W-1:0] ma, input logic [4:0] ra,
                              input logic de, input logic cur, input logic hs,
                              input logic vs, input int gap);
        exp_t e;
        bit   late_now, show, phase_ok;
        logic [7:0] code, f, r;
        late_now = m_valid && (m_gap < 5);
        show     = m_valid && !late_now && m_de;
        m_late   = m_late | late_now;
        e.row  = show ? m_row : 8'h00;
        e.de   = show;
        e.hs   = m_hs;
        e.vs   = m_vs;
        e.late = m_late;
        e.n    = (gap < 8) ? gap : 8;
        q.push_back(e);
`ifdef CURSOR_BLINK_EN
        if (vs && !m_vs) begin
            if (m_bcnt == BF - 1) begin m_bcnt = 0; m_phase = !m_phase; end
            else m_bcnt++;
        end
        phase_ok = m_phase;
`else
        phase_ok = 1;
`endif
        code = vram[ma];
        f    = font[{code, ra[3:0]}];
        r    = ra[4] ? 8'h00 : f;
        if (cur && de && phase_ok) r = ~r;
        m_row = r; m_de = de; m_hs = hs; m_vs = vs; m_gap = gap; m_valid = 1;
        MA = ma; RA = ra; DE = de; CURSOR = cur; HSYNC_IN = hs; VSYNC_IN = vs;
        CHAR_EN = 1'b1;
        @(negedge CLK);
        CHAR_EN = 1'b0;
        repeat (gap - 1) @(negedge CLK);
    endtask

    task automatic rand_char(input int gap, input logic hs, input logic vs);
        logic [4:0] ra;
        logic cur;
        ra  = ($urandom_range(0, 9) == 0) ? 5'(16 + $urandom_range(0, 15)) : 5'($urandom_range(0, 15));
        cur = ra[4] ? 1'b0 : ($urandom_range(0, 3) == 0);
        drive_char(MA_W'($urandom), ra, ($urandom_range(0, 4) != 0), cur, hs, vs, gap);
    endtask

    task automatic do_reset();
        RST = 1'b1; CHAR_EN = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        chk("rst_pixel", PIXEL, 0);
        chk("rst_pix_de", PIX_DE, 0);
        chk("rst_hsync", HSYNC_OUT, 0);
        chk("rst_vsync", VSYNC_OUT, 0);
        chk("rst_late", LATE, 0);
        chk("rst_vram_rd", VRAM_RD, 0);
        chk("rst_font_rd", FONT_RD, 0);
        chk("rst_vram_addr", VRAM_ADDR, 0);
        chk("rst_font_addr", FONT_ADDR, 0);
    endtask

    // Scoreboard monitor: every character strobe presents one loaded character
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            if (CHAR_EN && !RST) begin
                if (q.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    e = q.pop_front();
                    @(negedge CLK);
                    chk("pix_de", PIX_DE, e.de);
                    chk("hsync_out", HSYNC_OUT, e.hs);
                    chk("vsync_out", VSYNC_OUT, e.vs);
                    chk("late", LATE, e.late);
                    for (int i = 0; i < e.n; i++) begin
                        if (i > 0) @(negedge CLK);
                        chk($sformatf("pixel_dot%0d", i), PIXEL, e.row[7-i]);
                    end
                end
            end
        end
    end

    // Memory bus checker: addresses and single-cycle strobes
    logic [MA_W-1:0] f_ma = '0;
    logic [4:0]      f_ra = '0;
    logic            prev_vrd = 1'b0, prev_frd = 1'b0;

    always @(posedge CLK) if (CHAR_EN) begin f_ma <= MA; f_ra <= RA; end

    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (VRAM_RD) begin
                    chk("vram_addr", VRAM_ADDR, f_ma);
                    chk("vram_rd_single", prev_vrd, 0);
                end
                if (FONT_RD) begin
                    font_pulses++;
                    chk("font_addr", FONT_ADDR, {vram[f_ma], f_ra[3:0]});
                    chk("font_rd_single", prev_frd, 0);
                end
            end
            prev_vrd = VRAM_RD;
            prev_frd = FONT_RD;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fp0;
        int g;
        for (int i = 0; i < (1 << MA_W); i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 4096; i++) font[i] = 8'($urandom);
        vram[14'h0123] = 8'h41;
        font[12'h412]  = 8'h3C;
        model_reset();
        repeat (3) @(negedge CLK);
        do_reset();

        // Directed characters, then random stream with HSYNC on chars 10..13
        drive_char(14'h0123, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8);
        drive_char(14'h0123, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8);
        drive_char(14'h0123, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        for (int k = 3; k < 200; k++) begin
            g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 12)) : 8;
            if (k < 20)
                rand_char(g, (k >= 10 && k <= 13), 1'b0);
            else
                rand_char(g, 1'($urandom), ((k / 7) % 2 == 1));
        end
        rand_char(12, 1'b0, 1'b0);
        do_reset();

        // Short character periods
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 4))
                0:       g = 3;
                1:       g = 4;
                default: g = int'($urandom_range(5, 9));
            endcase
            if (k == 5) g = 3;
            rand_char(g, 1'($urandom), 1'($urandom));
        end
        rand_char(12, 1'b0, 1'b0);
        do_reset();

        // Reset landing on the font request edge aborts the fetch
        drive_char(14'h0123, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 2);
        fp0 = font_pulses;
        do_reset();
        repeat (6) @(negedge CLK);
        chk("abort_no_font_rd", font_pulses, fp0);
        drive_char(14'h0123, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8);
        drive_char(14'h0200, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8);

        // Cursor held while VSYNC pulses every other character
        for (int k = 0; k < 24; k++)
            drive_char(14'h0123, 5'd2, 1'b1, 1'b1, 1'b0, (k % 2 == 1), 8);
        rand_char(12, 1'b0, 1'b0);

        repeat (4) @(negedge CLK);
        chk("scoreboard_drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
